// File: rtl/class_argmax.sv
// rtl/class_argmax.sv - streaming argmax over NUM_CLASSES IEEE-754 scores per frame
// Optional build macro: CLASS_ARGMAX_NAN_FILTER_EN (NaN scores never win)
module class_argmax #(
    parameter int NUM_CLASSES = 10,
    parameter int IDX_W       = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      din,
    input  logic             tvalid_in,
    output logic             tready_in,
    input  logic             clear,
    output logic [IDX_W-1:0] dout,
    output logic [31:0]      max_score,
    output logic             tvalid_out,
    input  logic             tready_out
);

    localparam int CNT_W = (NUM_CLASSES > 1) ? $clog2(NUM_CLASSES) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(NUM_CLASSES - 1);

    typedef enum logic {
        ST_COLLECT,
        ST_OUTPUT
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             accept;
    logic             take;
    logic [31:0]      load_val;

    // IEEE-754 "a > b" on raw bits; +0 and -0 are equal.
    function automatic logic fp_gt(input logic [31:0] a, input logic [31:0] b);
        if (a[30:0] == '0 && b[30:0] == '0)
            return 1'b0;
        if (a[31] != b[31])
            return !a[31];
        if (!a[31])
            return a[30:0] > b[30:0];
        return a[30:0] < b[30:0];
    endfunction

`ifdef CLASS_ARGMAX_NAN_FILTER_EN
    function automatic logic is_nan(input logic [31:0] x);
        return (x[30:23] == 8'hFF) && (x[22:0] != '0);
    endfunction
`endif

    assign accept = tvalid_in && tready_in && (state == ST_COLLECT);

    always_comb begin
        take     = 1'b0;
        load_val = din;
`ifdef CLASS_ARGMAX_NAN_FILTER_EN
        // A NaN first beat is parked as the canonical quiet NaN so any real score displaces it.
        if (cnt == '0) begin
            take     = 1'b1;
            load_val = is_nan(din) ? 32'h7FC0_0000 : din;
        end else begin
            take = !is_nan(din) && (is_nan(max_score) || fp_gt(din, max_score));
        end
`else
        take = (cnt == '0) || fp_gt(din, max_score);
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_COLLECT;
            cnt        <= '0;
            tready_in  <= 1'b0;
            tvalid_out <= 1'b0;
            dout       <= '0;
            max_score  <= 32'h0000_0000;
        end else if (clear) begin
            state      <= ST_COLLECT;
            cnt        <= '0;
            tready_in  <= 1'b1;
            tvalid_out <= 1'b0;
        end else begin
            case (state)
                ST_COLLECT: begin
                    tready_in <= 1'b1;
                    if (accept) begin
                        if (take) begin
                            max_score <= load_val;
                            dout      <= IDX_W'(cnt);
                        end
                        if (cnt == LAST_BEAT) begin
                            state      <= ST_OUTPUT;
                            cnt        <= '0;
                            tready_in  <= 1'b0;
                            tvalid_out <= 1'b1;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                end
                ST_OUTPUT: begin
                    if (tready_out) begin
                        state      <= ST_COLLECT;
                        tready_in  <= 1'b1;
                        tvalid_out <= 1'b0;
                    end
                end
                default: begin
                    state      <= ST_COLLECT;
                    cnt        <= '0;
                    tvalid_out <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_class_argmax.sv
// tb/tb_class_argmax.sv - self-checking bench for class_argmax with a real-valued reference model
module tb_class_argmax;

    localparam int N = 10;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] din = '0;
    logic        tvalid_in = 1'b0;
    logic        tready_in;
    logic        clear = 1'b0;
    logic [3:0]  dout;
    logic [31:0] max_score;
    logic        tvalid_out;
    logic        tready_out = 1'b1;

    int checks = 0;
    int errors = 0;

    logic [31:0] frame [N];
    int          gap_pct = 0;

    class_argmax #(.NUM_CLASSES(N), .IDX_W(4)) dut (
        .clk(clk), .rst(rst), .din(din), .tvalid_in(tvalid_in), .tready_in(tready_in),
        .clear(clear), .dout(dout), .max_score(max_score), .tvalid_out(tvalid_out),
        .tready_out(tready_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Numeric value of a finite single-precision pattern.
    function automatic real f2r(input logic [31:0] b);
        real m, v;
        int  e;
        m = real'(b[22:0]);
        e = int'(b[30:23]);
        if (e == 0) v = m * (2.0 ** (-149));
        else        v = (1.0 + m / 8388608.0) * (2.0 ** (e - 127));
        return b[31] ? -v : v;
    endfunction

    function automatic int ref_idx();
        int best = 0;
        for (int i = 1; i < N; i++)
            if (f2r(frame[i]) > f2r(frame[best])) best = i;
        return best;
    endfunction

    function automatic logic [31:0] rand_score(input int i);
        logic [31:0] s;
        int r = $urandom_range(0, 9);
        if (r == 0 && i > 0) return frame[$urandom_range(0, i - 1)];
        if (r == 1) return {$urandom_range(0, 1) == 1, 31'h0};
        s[31]    = $urandom_range(0, 1) == 1;
        s[30:23] = 8'($urandom_range(120, 134));
        s[22:0]  = 23'($urandom);
        return s;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_beats(input int count);
        for (int i = 0; i < count; i++) begin
            int t = 0;
            while (($urandom_range(0, 99) < gap_pct) && t < 3) begin
                tvalid_in = 1'b0;
                step();
                t++;
            end
            din = frame[i];
            tvalid_in = 1'b1;
            t = 0;
            while (!tready_in && t < 50) begin
                step();
                t++;
            end
            if (t >= 50) chk("accept_timeout", 32'(tready_in), 32'd1);
            step();
        end
        tvalid_in = 1'b0;
    endtask

    task automatic run_frame(input string tag, input int hold);
        int exp_i;
        exp_i = ref_idx();
        tready_out = (hold == 0);
        send_beats(N);
        chk({tag, "_valid"}, 32'(tvalid_out), 32'd1);
        chk({tag, "_dout"}, 32'(dout), 32'(exp_i));
        chk({tag, "_score"}, max_score, frame[exp_i]);
        chk({tag, "_rdy_out_state"}, 32'(tready_in), 32'd0);
        for (int c = 0; c < hold; c++) begin
            step();
            chk({tag, "_hold"}, {tready_in, tvalid_out, 26'(dout), 4'h0},
                {1'b0, 1'b1, 26'(exp_i), 4'h0});
            chk({tag, "_hold_score"}, max_score, frame[exp_i]);
        end
        tready_out = 1'b1;
        step();
        chk({tag, "_valid_drop"}, 32'(tvalid_out), 32'd0);
        chk({tag, "_ready_back"}, 32'(tready_in), 32'd1);
    endtask

    initial begin
        #12;
        chk("rst_ready", 32'(tready_in), 32'd0);
        chk("rst_valid", 32'(tvalid_out), 32'd0);
        chk("rst_dout", 32'(dout), 32'd0);
        chk("rst_score", max_score, 32'h0);
        step();
        rst = 1'b0;
        chk("rel_ready_low", 32'(tready_in), 32'd0);
        step();
        chk("rel_ready_high", 32'(tready_in), 32'd1);

        frame = '{32'h3DCCCCCD, 32'h3E4CCCCD, 32'h3E99999A, 32'h3ECCCCCD, 32'h3F000000,
                  32'h3F19999A, 32'h3F333333, 32'h3F4CCCCD, 32'h3F666666, 32'h3D4CCCCD};
        chk("ascend_model", 32'(ref_idx()), 32'd8);
        run_frame("ascend", 0);

        frame = '{32'h3DCCCCCD, 32'h3E4CCCCD, 32'h3E99999A, 32'h3F333333, 32'h3F000000,
                  32'h3F19999A, 32'h3F333333, 32'h3F000000, 32'h3E99999A, 32'h3D4CCCCD};
        run_frame("tie", 0);

        frame = '{32'hBF800000, 32'hC0000000, 32'hC0400000, 32'hC0800000, 32'hC0A00000,
                  32'hC0C00000, 32'hC0E00000, 32'hC1000000, 32'hC1100000, 32'hBF000000};
        run_frame("neg", 0);

        frame = '{32'h80000000, 32'hC0000000, 32'h00000000, 32'hC0800000, 32'hC0A00000,
                  32'hC0C00000, 32'hC0E00000, 32'hC1000000, 32'hC1100000, 32'hBF000000};
        run_frame("zeros", 0);

        gap_pct = 40;
        for (int i = 0; i < N; i++) frame[i] = rand_score(i);
        run_frame("backpressure", 20);

        for (int f = 0; f < 6; f++) begin
            for (int i = 0; i < N; i++) frame[i] = rand_score(i);
            run_frame($sformatf("rand%0d", f), $urandom_range(0, 3));
        end
        gap_pct = 0;

        frame = '{32'h7F000000, 32'h7F000000, 32'h7F000000, 32'h7F000000, 32'h7F000000,
                  32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
        send_beats(5);
        clear = 1'b1;
        step();
        clear = 1'b0;
        chk("clear_valid", 32'(tvalid_out), 32'd0);
        chk("clear_ready", 32'(tready_in), 32'd1);
        for (int i = 0; i < N; i++) frame[i] = rand_score(i);
        frame[0][30:23] = 8'd110;
        run_frame("after_clear", 0);

        for (int i = 0; i < N; i++) frame[i] = rand_score(i);
        tready_out = 1'b0;
        send_beats(N);
        chk("pre_rst_valid", 32'(tvalid_out), 32'd1);
        rst = 1'b1;
        #1;
        chk("rst_out_valid", 32'(tvalid_out), 32'd0);
        chk("rst_out_ready", 32'(tready_in), 32'd0);
        step();
        rst = 1'b0;
        tready_out = 1'b1;
        chk("rst_out_rel_low", 32'(tready_in), 32'd0);
        step();
        chk("rst_out_rel_high", 32'(tready_in), 32'd1);

        frame = '{32'h7FC00000, 32'h3DCCCCCD, 32'h3E4CCCCD, 32'h3E4CCCCD, 32'h3E99999A,
                  32'h3DCCCCCD, 32'h3D4CCCCD, 32'h3E4CCCCD, 32'h3DCCCCCD, 32'h3D4CCCCD};
        send_beats(N);
        chk("nan_valid", 32'(tvalid_out), 32'd1);
`ifdef CLASS_ARGMAX_NAN_FILTER_EN
        chk("nan_dout", 32'(dout), 32'd4);
        chk("nan_score", max_score, 32'h3E99999A);
`else
        chk("nan_dout", 32'(dout), 32'd0);
        chk("nan_score", max_score, 32'h7FC00000);
`endif
        step();
        chk("nan_valid_drop", 32'(tvalid_out), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/class_argmax.md
CLASS_ARGMAX -- requirements
Module: class_argmax

Interface
REQ-001 Parameter NUM_CLASSES, default 10, number of float scores per image frame (2..64).
REQ-002 Parameter IDX_W, default 4, width of class index output; SHALL satisfy 2**IDX_W >= NUM_CLASSES.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 din  input  32  IEEE-754 single-precision score from the neuron stage.
REQ-006 tvalid_in  input  1  din valid.
REQ-007 tready_in  output  1  block accepts din; a beat transfers when tvalid_in && tready_in at a rising edge.
REQ-008 clear  input  1  synchronous abort of the current frame.
REQ-009 dout  output  IDX_W  winning class index (0-based, arrival order).
REQ-010 max_score  output  32  score of the winning class.
REQ-011 tvalid_out  output  1  dout/max_score valid.
REQ-012 tready_out  input  1  consumer accepts result; transfer when tvalid_out && tready_out at a rising edge.

Function
REQ-013 Two states: COLLECT (tready_in=1, tvalid_out=0) and OUTPUT (tready_in=0, tvalid_out=1).
REQ-014 In COLLECT, each accepted beat increments beat counter cnt (0..NUM_CLASSES-1) and is compared against the running maximum.
REQ-015 First beat of a frame (cnt=0) unconditionally loads running max and index 0.
REQ-016 Later beats replace running max and index only if strictly greater; ties keep the lower index.
REQ-017 Comparison SHALL be full IEEE-754 ordering: positive > negative; both positive -> larger magnitude bits win; both negative -> smaller magnitude bits win; +0 and -0 compare equal.
REQ-018 Acceptance of beat NUM_CLASSES-1 SHALL move the block to OUTPUT on the same edge, with dout/max_score holding the final result; tvalid_out is high the cycle after the last accept (latency 1).
REQ-019 In OUTPUT, dout, max_score and tvalid_out SHALL remain stable until tready_out=1; on that edge the state returns to COLLECT, cnt=0, tready_in=1 next cycle.
REQ-020 Back-pressure: arbitrary tvalid_in gaps in COLLECT SHALL not change the result; tready_out low for any number of cycles SHALL not lose the result.
REQ-021 clear=1 at an edge SHALL force COLLECT, cnt=0, tvalid_out=0, discarding any partial frame or unconsumed result; clear dominates a simultaneous input or output transfer.
REQ-022 dout and max_score SHALL be driven from registers only; no combinational path from din to any output.

Reset
REQ-023 On rst=1, immediately: state COLLECT, cnt=0, tready_in=0, tvalid_out=0, dout=0, max_score=32'h0000_0000.
REQ-024 tready_in SHALL rise on the first rising edge after rst deasserts; rst mid-frame or mid-OUTPUT discards all progress.

Configuration
REQ-025 Macro CLASS_ARGMAX_NAN_FILTER_EN: when defined, an input with exponent 8'hFF and nonzero mantissa (NaN) SHALL never win a comparison (still counts as a beat); a NaN first beat is replaced by the first non-NaN beat; an all-NaN frame reports dout=0, max_score=32'h7FC0_0000.
REQ-026 When undefined, NaN inputs are compared by the REQ-017 sign/magnitude rule on raw bits, with no special handling.

Verification
REQ-027 NUM_CLASSES=10, scores 0.1,0.2,...,0.9,0.05 (one beat per cycle, tready_out=1) -> dout=8, max_score=32'h3F66_6666, tvalid_out high exactly one cycle, 1 cycle after last accept.
REQ-028 Scores with equal maximum 0.7 at indices 3 and 6 -> dout=3.
REQ-029 All-negative frame -1.0..-10.0 with -0.5 at index 9 -> dout=9, max_score=32'hBF00_0000; +0.0 at index 2 and -0.0 at index 0, rest negative -> dout=0.
REQ-030 tvalid_in random gaps and tready_out held low 20 cycles -> result unchanged and stable, tready_in=0 throughout OUTPUT, next frame accepted after handshake.
REQ-031 clear asserted after 5 beats, then full new frame -> only new frame's argmax reported; rst asserted in OUTPUT -> tvalid_out=0 immediately, tready_in=1 one edge after release.
REQ-032 With CLASS_ARGMAX_NAN_FILTER_EN, NaN 32'h7FC0_0000 at index 0 and 0.3 maximum at index 4 -> dout=4; without macro, same frame -> dout=0.
